// File: rtl/adder_stim_driver.sv
// Stimulus driver and response checker for a 4-bit adder: drives a sweep or
// LFSR operand sequence, samples the sum at the end of each hold window.
module adder_stim_driver #(
  parameter int         HOLD = 2,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [8:0] num_vec,
  output logic [3:0] a,
  output logic [3:0] b,
  input  logic [4:0] s,
  output logic       busy,
  output logic       done,
  output logic [8:0] vec_cnt,
  output logic [8:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_e;

  localparam logic [7:0] SEED_L    = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_e     state_q, state_d;
  logic [7:0] vec_q, vec_d;
  logic [3:0] hold_q, hold_d;
  logic       mode_q, mode_d;
  logic [8:0] nv_q, nv_d;
  logic [8:0] vc_q, vc_d;
  logic [8:0] ec_q, ec_d;

  logic [4:0] exp_sum;
  logic [7:0] vec_next;

  assign exp_sum  = {1'b0, vec_q[7:4]} + {1'b0, vec_q[3:0]};
  // Sweep wraps naturally at 256; LFSR taps x^8+x^6+x^5+x^4+1, shifting left.
  assign vec_next = mode_q ? {vec_q[6:0], vec_q[7] ^ vec_q[5] ^ vec_q[4] ^ vec_q[3]}
                           : vec_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 8'h00;
      hold_q  <= 4'd0;
      mode_q  <= 1'b0;
      nv_q    <= 9'd0;
      vc_q    <= 9'd0;
      ec_q    <= 9'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      nv_q    <= nv_d;
      vc_q    <= vc_d;
      ec_q    <= ec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    nv_d    = nv_q;
    vc_d    = vc_q;
    ec_d    = ec_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          vc_d = 9'd0;
          ec_d = 9'd0;
          if (num_vec != 9'd0) begin
            mode_d  = mode;
            nv_d    = num_vec;
            vec_d   = mode ? SEED_L : 8'h00;
            hold_d  = 4'd0;
            state_d = DRIVE;
          end else begin
            state_d = FIN;
          end
        end
      end
      DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          if (s != exp_sum && ec_q != 9'd511) ec_d = ec_q + 9'd1;
          vc_d = vc_q + 9'd1;
          if ({1'b0, vc_q} + 10'd1 == {1'b0, nv_q}) begin
            state_d = FIN;
          end else begin
            vec_d  = vec_next;
            hold_d = 4'd0;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == DRIVE);
  assign done    = (state_q == FIN);
  assign a       = busy ? vec_q[7:4] : 4'd0;
  assign b       = busy ? vec_q[3:0] : 4'd0;
  assign vec_cnt = vc_q;
  assign err_cnt = ec_q;

endmodule

// File: tb/tb_adder_stim_driver.sv
// Self-checking bench: directed and randomized runs against a sequence/score model.
module tb_adder_stim_driver;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [8:0] num_vec = 9'd0;
  logic [3:0] a, b;
  logic [4:0] s;
  logic       busy, done;
  logic [8:0] vec_cnt, err_cnt;

  int errors = 0;
  int checks = 0;
  logic fault_en = 1'b0;
  int   fault_bit = 0;

  adder_stim_driver #(.HOLD(HOLD), .SEED(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_vec(num_vec),
    .a(a), .b(b), .s(s), .busy(busy), .done(done),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Adder under test: ideal, or with one sum bit stuck at 0.
  always_comb begin
    s = 5'(a) + 5'(b);
    if (fault_en) s = s & ~(5'd1 << fault_bit);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_step(input int v);
    int fbk;
    fbk = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | fbk) & 255;
  endfunction

  task automatic run(input bit m, input int nv, input bit fen, input int fb, input bit restart_mid);
    int exp_vec[$];
    int v, sum, seen, exp_err, c, k, bad_ab, busy_bad;
    v = 8'hA5;
    exp_err = 0; bad_ab = 0; busy_bad = 0;
    for (int i = 0; i < nv; i++) begin
      exp_vec.push_back(m ? v : i % 256);
      if (m) v = lfsr_step(v);
    end
    foreach (exp_vec[i]) begin
      sum  = (exp_vec[i] >> 4) + (exp_vec[i] & 15);
      seen = fen ? (sum & ~(1 << fb)) : sum;
      if (seen != sum) exp_err++;
    end
    fault_en = fen; fault_bit = fb;
    @(negedge clk);
    mode = m; num_vec = 9'(nv); start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~m; num_vec = 9'($urandom);
    c = 1;
    while (!done && c <= nv * HOLD + 4) begin
      if (!busy) busy_bad++;
      k = (c - 1) / HOLD;
      if (k < nv && {a, b} !== 8'(exp_vec[k])) bad_ab++;
      start = (restart_mid && c == 3);
      if (start) num_vec = 9'($urandom_range(1, 511));
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("done_cycle", c, nv * HOLD + 1);
    chk("vector_seq_mismatches", bad_ab, 0);
    chk("busy_low_in_drive", busy_bad, 0);
    chk("busy_at_done", busy, 0);
    chk("ab_at_done", {a, b}, 0);
    chk("vec_cnt", vec_cnt, nv);
    chk("err_cnt", err_cnt, exp_err);
    // start in the done cycle must be ignored
    start = 1'b1; num_vec = 9'd5;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("start_in_done_ignored", busy, 0);
    chk("vec_cnt_held", vec_cnt, nv);
    fault_en = 1'b0;
  endtask

  initial begin
    int done_seen;
    // reset with start asserted
    rst_n = 1'b0; start = 1'b1; num_vec = 9'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ab", {a, b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    start = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    run(1'b0, 256, 1'b0, 0, 1'b0);   // full sweep, ideal adder
    run(1'b0, 256, 1'b1, 0, 1'b0);   // s[0] stuck at 0
    run(1'b1, 3,   1'b0, 0, 1'b0);   // LFSR A5, 4A, 95
    run(1'b0, 0,   1'b0, 0, 1'b0);   // empty run
    run(1'b0, 20,  1'b0, 0, 1'b1);   // second start mid-run
    run(1'b0, 300, 1'b0, 0, 1'b0);   // sweep wrap

    // reset mid-run at vector 10
    @(negedge clk);
    mode = 1'b0; num_vec = 9'd50; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10 * HOLD) @(negedge clk);
    chk("pre_reset_vector", {a, b}, 10);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_ab", {a, b}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_vec_cnt", vec_cnt, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("no_activity_after_abort", done_seen, 0);
    run(1'b0, 12, 1'b0, 0, 1'b0);

    // randomized runs
    for (int i = 0; i < 8; i++)
      run(1'($urandom_range(0, 1)), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
          $urandom_range(0, 4), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder_stim_driver.md
# adder_stim_driver

Synthesizable stimulus driver and response checker for the 4-bit adder verification environment. It is the driving end of the adder interface. On a start pulse it drives a programmed number of operand pairs onto `a`/`b`, using either an exhaustive sweep or an 8-bit LFSR sequence. It holds each pair for a fixed number of cycles, samples `s` on the last hold cycle, compares it against the expected `a + b`, and reports vector and error counts with a done pulse.

## Interface
Parameters:
- `HOLD`, default 2: cycles each operand pair is held on `a`/`b`; legal range 1..15.
- `SEED`, default 8'hA5: LFSR load value at start. 8'h00 is illegal and is replaced by 8'h01.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  in  1  one-cycle request to begin a run; ignored unless in IDLE.
- `mode`  in  1  0 = sweep, 1 = LFSR; sampled with `start`.
- `num_vec`  in  9  number of vectors in the run (0..511); sampled with `start`.
- `a`  out  4  operand A to the adder.
- `b`  out  4  operand B to the adder.
- `s`  in  5  adder sum from the DUT.
- `busy`  out  1  high while vectors are being driven.
- `done`  out  1  one-cycle pulse at end of run.
- `vec_cnt`  out  9  vectors completed in the current or last run.
- `err_cnt`  out  9  mismatches in the current or last run.

## Operation
- FSM states: IDLE, DRIVE, FIN.
- IDLE
  - `a` = `b` = 0, `busy` = 0, counters hold their values.
  - On `start` with `num_vec` != 0: latch `mode`/`num_vec`, clear `vec_cnt`/`err_cnt`, load vector 0 onto `a`/`b`, go to DRIVE.
  - On `start` with `num_vec` == 0: clear both counters, go to FIN. No vector is driven.
- DRIVE
  - `busy` = 1.
  - An internal hold counter runs 0..HOLD-1.
  - On hold == HOLD-1:
    - Compare `s` to the 5-bit zero-extended `a + b`.
    - Increment `err_cnt` on mismatch, saturating at 511.
    - Increment `vec_cnt`.
    - If `vec_cnt` + 1 == latched `num_vec`, go to FIN; otherwise advance to the next vector and reset the hold counter.
- FIN: `done` = 1 for exactly one cycle, `a` = `b` = 0, `busy` = 0, go to IDLE.
- Sweep sequence
  - Vector k drives {a,b} = k[7:0], so `a` = k[7:4] and `b` = k[3:0].
  - Runs longer than 256 wrap: k = 256 repeats {0,0}.
- LFSR sequence
  - 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifting left. The new bit 0 is s[7]^s[5]^s[4]^s[3].
  - Vector 0 = seed; each subsequent vector = the next state. {a,b} = state.
- `start` while in DRIVE or FIN is ignored. It is neither queued nor does it restart the run.
- Changes on `mode`/`num_vec` while not starting have no effect.

## Timing
- Reset (`rst_n` low at an edge): the state goes to IDLE, and `a`, `b`, `busy`, `done`, `vec_cnt`, `err_cnt` all become 0. The LFSR register also becomes 0.
- Reset mid-run aborts the run with no done pulse. Outputs take reset values at that same edge.
- `start` sampled at edge E0:
  - Vector 0 appears on `a`/`b` and `busy` rises after E0.
  - Vector k is driven during cycles [1 + k·HOLD, (k+1)·HOLD] after E0.
  - `done` is high in the cycle starting at edge E0 + num_vec·HOLD + 1; `busy` falls at that same edge.
- `s` is sampled at the last edge of each vector's hold window. The DUT therefore has HOLD-1 full cycles plus combinational settle time. With HOLD = 1, `s` must be valid within the same cycle.
- `vec_cnt`/`err_cnt` update at the sampling edge and are stable when `done` is high.
- Earliest restart: a `start` during the `done` cycle is ignored. The first accepted `start` is in the cycle after `done`.

## Test plan
- Reset and idle: hold `rst_n` low 3 cycles → `a` = `b` = 0, `busy` = `done` = 0, `vec_cnt` = `err_cnt` = 0. `start` asserted during reset has no effect.
- Full sweep with ideal adder, HOLD = 2, `mode` = 0, `num_vec` = 256:
  - Vectors {0,0} through {15,15} are driven in order; the last vector gives `s` = 30.
  - `done` is high 513 cycles after the start edge; `vec_cnt` = 256, `err_cnt` = 0.
- Faulty DUT: force `s[0]` stuck-at-0, sweep 256 → `err_cnt` = 128, i.e. every pair with an odd sum.
- LFSR mode, SEED = 8'hA5, `num_vec` = 3 → driven vectors are {A,5}, then 8'h4A ({4,A}), then 8'h95 ({9,5}); `done` arrives at cycle 3·HOLD + 1.
- Boundaries:
  - `num_vec` = 0 → `done` in the cycle after `start`, counts stay 0, `busy` never rises.
  - A second `start` mid-run is ignored and the run completes with its original count.
  - `num_vec` = 300 in sweep mode → vector 256 = {0,0} (wrap), `vec_cnt` = 300.
- Reset mid-run: drop `rst_n` at vector 10 → all outputs 0 at the next edge, no `done` pulse. A new `start` then runs cleanly from vector 0.
